rr_hold_scheduler: RTL and testbench
====================================

// Module: rr_hold_scheduler
// PURPOSE
//  Round-robin scheduler that shares one resource among N requesters. A grant is
//  held across a multi-cycle transaction, and fairness rotates after each release.
//  Sits in front of the shared datapath and drives its per-requester select.
//  Each ownership ends on one of three events: done, requester abandon, or hold timeout.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  MAX_HOLD  16  max cycles a grant may be held; 0 = timeout disabled
//  ID_W      $clog2(N)  width of gnt_id (derived, not overridden)
//  CNT_W     $clog2(MAX_HOLD+1)  hold counter width (derived)
// PORTS
//  clk       in   1     clock, rising edge
//  rst       in   1     reset, asynchronous, active-low (0 = reset)
//  req       in   N     per-requester request, level
//  done      in   1     resource signals end of current transaction (1-cycle pulse)
//  gnt       out  N     one-hot grant, registered; all-zero when idle
//  gnt_id    out  ID_W  binary index of granted requester; 0 when idle
//  busy      out  1     1 while a grant is held (== |gnt)
//  timeout   out  1     1-cycle pulse on the cycle the grant is revoked by timeout
// BEHAVIOUR
//  Reset: async assert -> state=IDLE, gnt=0, gnt_id=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
//   Applies mid-transaction too: grant dropped immediately, no timeout pulse.
//  State machine: IDLE, BUSY, REL.
//  IDLE: if |req at edge -> BUSY; gnt = RR pick, visible the next cycle (1-cycle latency).
//   RR pick: first asserted req at index ptr, ptr+1, ... wrapping modulo N.
//   ptr=0 after reset, so requester 0 has priority first.
//  BUSY: gnt/gnt_id are frozen; changes on other req bits are ignored.
//   hold_cnt = 0 on the first BUSY cycle and increments by 1 each BUSY cycle.
//   Release conditions, evaluated each BUSY cycle in this priority order:
//   1) done=1 -> REL
//   2) req[gnt_id]=0 (abandon) -> REL
//   3) MAX_HOLD!=0 && hold_cnt==MAX_HOLD-1 -> REL, with timeout=1 on the following cycle.
//   done with abandon or timeout in the same cycle: treated as done, no timeout pulse.
//   On release: ptr <= (gnt_id+1) mod N; wrap from N-1 to 0.
//  REL: exactly one cycle with gnt=0, busy=0 (bubble); timeout pulses here if
//   applicable. Then -> IDLE behaviour: REL evaluates req like IDLE, so next grant
//   appears the cycle after REL. Gap between grants is 1 cycle.
//  done is ignored in IDLE/REL. hold_cnt saturates; it never wraps while BUSY.
//  Outputs are driven only from flops; no combinational path from req/done to gnt.
//  Invariant: gnt is one-hot or zero; gnt_id matches gnt when busy=1.
// TESTING
//  T1 reset: rst=0 with req=4'hF -> gnt=0, gnt_id=0, busy=0, timeout=0.
//   rst=1 -> gnt=4'b0001 one cycle after first edge.
//  T2 fairness: req=4'hF held, done pulsed 2 cycles after each grant
//   -> grant order 0,1,2,3,0; one idle cycle between each grant.
//  T3 hold: grant to 1 with req 4'b0010; raise req=4'b1111 while BUSY
//   -> gnt stays 4'b0010 until done; next grant goes to 2.
//  T4 timeout: MAX_HOLD=4, req=4'b0100, no done -> gnt=4'b0100 for exactly 4 cycles.
//   timeout=1 on the REL cycle; re-grant to 2 follows since req remains.
//  T5 abandon/simultaneous: drop req[gnt_id] -> release, no timeout pulse.
//   Assert done on the timeout cycle -> release with timeout=0.
//  T6 reset mid-grant: rst=0 during BUSY of requester 3 -> gnt=0 asynchronously.
//   After release of reset, req=4'hF -> grant goes to 0 (ptr reset).

Source files
------------

// File: rtl/rr_hold_scheduler.sv
// rr_hold_scheduler: round-robin grant of one shared resource, held until done, abandon or timeout
//   clk_i      rising-edge clock
//   rst_ni     asynchronous active-low reset
//   req_i      per-requester level request
//   done_i     end of the current transaction (1-cycle pulse)
//   gnt_o      registered one-hot grant, zero when idle
//   gnt_id_o   index of the granted requester, zero when idle
//   busy_o     high while a grant is held
//   timeout_o  1-cycle pulse on the bubble cycle after a timeout revoke
module rr_hold_scheduler #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 16,
  localparam int ID_W    = $clog2(N),
  localparam int CNT_W   = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [N-1:0]    req_i,
  input  logic            done_i,
  output logic [N-1:0]    gnt_o,
  output logic [ID_W-1:0] gnt_id_o,
  output logic            busy_o,
  output logic            timeout_o
);
  typedef enum logic [1:0] {IDLE, BUSY, REL} state_e;
  state_e           state_q;
  logic [N-1:0]     gnt_q;
  logic [ID_W-1:0]  gnt_id_q, ptr_q, pick_d, idx;
  logic [CNT_W-1:0] hold_cnt_q;
  logic             busy_q, timeout_q, tmo, rel;
  // Scan downward from the farthest slot so the nearest asserted request at/after ptr wins.
  always_comb begin
    pick_d = ptr_q;
    idx    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = ID_W'((int'(ptr_q) + i) % N);
      if (req_i[idx]) pick_d = idx;
    end
  end
  assign tmo = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));
  assign rel = done_i || !req_i[gnt_id_q] || tmo;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      ptr_q      <= '0;
      hold_cnt_q <= '0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        BUSY: begin
          if (rel) begin
            state_q   <= REL;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            ptr_q     <= (gnt_id_q == ID_W'(N - 1)) ? '0 : gnt_id_q + 1'b1;
            // done and abandon take precedence, so only a pure timeout pulses
            timeout_q <= !done_i && req_i[gnt_id_q];
          end else if (hold_cnt_q != '1) begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: begin
          if (|req_i) begin
            state_q    <= BUSY;
            gnt_q      <= N'(1) << pick_d;
            gnt_id_q   <= pick_d;
            busy_q     <= 1'b1;
            hold_cnt_q <= '0;
          end else begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end
  assign gnt_o     = gnt_q;
  assign gnt_id_o  = gnt_id_q;
  assign busy_o    = busy_q;
  assign timeout_o = timeout_q;
endmodule

// File: tb/tb_rr_hold_scheduler.sv
// tb_rr_hold_scheduler: cycle-vector scoreboard bench for rr_hold_scheduler (N=4, MAX_HOLD=4)
module tb_rr_hold_scheduler;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'hF;
  logic       done = 1'b0;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy, timeout;
  int total = 0;
  int bad = 0;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       busy;
    logic       tmo;
  } vec_t;

  vec_t vq[$];
  vec_t sb[$];
  vec_t e;

  rr_hold_scheduler #(.N(4), .MAX_HOLD(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .done_i(done),
    .gnt_o(gnt), .gnt_id_o(gnt_id), .busy_o(busy), .timeout_o(timeout)
  );

  always #5 clk = ~clk;

  task automatic v(input logic r, input logic [3:0] rq, input logic d,
                   input logic [3:0] g, input logic [1:0] id, input logic b, input logic t);
    vec_t x;
    x.rst_n = r; x.req = rq; x.done = d; x.gnt = g; x.id = id; x.busy = b; x.tmo = t;
    vq.push_back(x);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [1:0] id,
                         input logic b, input logic t);
    chk({tag, " gnt"}, gnt, g);
    chk({tag, " gnt_id"}, {2'b0, gnt_id}, {2'b0, id});
    chk({tag, " busy"}, {3'b0, busy}, {3'b0, b});
    chk({tag, " timeout"}, {3'b0, timeout}, {3'b0, t});
  endtask

  initial begin
    // reset with all requests pending
    v(0, 4'hF, 0, 4'b0000, 0, 0, 0);
    // fairness: done two cycles into each grant -> 0,1,2,3,0 with one bubble
    v(1, 4'hF, 0, 4'b0001, 0, 1, 0);
    v(1, 4'hF, 0, 4'b0001, 0, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    v(1, 4'hF, 0, 4'b0010, 1, 1, 0);
    v(1, 4'hF, 0, 4'b0010, 1, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    v(1, 4'hF, 0, 4'b0100, 2, 1, 0);
    v(1, 4'hF, 0, 4'b0100, 2, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    v(1, 4'hF, 0, 4'b1000, 3, 1, 0);
    v(1, 4'hF, 0, 4'b1000, 3, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    v(1, 4'hF, 0, 4'b0001, 0, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    // hold: other requests rise while requester 1 owns the grant
    v(1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    v(1, 4'hF, 0, 4'b0010, 1, 1, 0);
    v(1, 4'hF, 1, 4'b0000, 0, 0, 0);
    v(1, 4'hF, 0, 4'b0100, 2, 1, 0);
    // timeout: lone requester 2 holds for exactly 4 cycles, pulse in bubble, re-grant
    v(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    v(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    v(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    v(1, 4'b0100, 0, 4'b0000, 0, 0, 1);
    v(1, 4'b0100, 0, 4'b0100, 2, 1, 0);
    // abandon, then idle, then ptr=3 picks requester 3
    v(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    v(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    v(1, 4'b1001, 0, 4'b1000, 3, 1, 0);
    v(1, 4'b1001, 0, 4'b1000, 3, 1, 0);
    v(1, 4'b1001, 0, 4'b1000, 3, 1, 0);
    v(1, 4'b1001, 0, 4'b1000, 3, 1, 0);
    // done on the timeout cycle: release without pulse, ptr wraps to 0
    v(1, 4'b1001, 1, 4'b0000, 0, 0, 0);
    v(1, 4'b1001, 0, 4'b0001, 0, 1, 0);
    // done together with abandon; done ignored while idle
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    v(1, 4'b0000, 1, 4'b0000, 0, 0, 0);
    v(1, 4'b0010, 1, 4'b0010, 1, 1, 0);
    v(1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    v(1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    v(1, 4'b0010, 0, 4'b0010, 1, 1, 0);
    // abandon on the timeout cycle: no pulse
    v(1, 4'b0000, 0, 4'b0000, 0, 0, 0);
    v(1, 4'b1000, 0, 4'b1000, 3, 1, 0);
    for (int i = 0; i < vq.size(); i++) begin
      rst_n = vq[i].rst_n;
      req   = vq[i].req;
      done  = vq[i].done;
      sb.push_back(vq[i]);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk_all($sformatf("v%0d", i), e.gnt, e.id, e.busy, e.tmo);
    end
    // asynchronous reset while requester 3 is busy
    #2;
    rst_n = 1'b0;
    req = 4'hF;
    done = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 0, 0, 0);
    @(posedge clk);
    #1;
    chk_all("rst_hold", 4'b0000, 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_all("post_rst_ptr0", 4'b0001, 0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
